// File: rtl/wshb_pkg.sv
// Shared Wishbone definitions: cycle-type / burst-type codes and the pixel reader state encoding.
package wshb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // One-hot so each state is a single flop a checker can bind to.
  typedef enum logic [2:0] {
    RD_IDLE  = 3'b001,
    RD_BURST = 3'b010,
    RD_GAP   = 3'b100
  } rd_state_t;

endpackage

// File: rtl/wshb_pixel_reader_if.sv
// Wishbone B4 bus bundle between the pixel reader (master) and the interconnect port (slave).
interface wshb_pixel_reader_if;

  // Handshake: a beat transfers on every cycle with wb_stb && wb_ack. While wb_stb is high and
  // wb_ack is low the master holds wb_adr/wb_cti stable; wb_ack with wb_stb low carries nothing.
  logic [31:0] wb_adr;
  logic [15:0] wb_dat_sm;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [1:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic        wb_ack;

  modport master (
    output wb_adr, wb_cyc, wb_stb, wb_we, wb_sel, wb_cti, wb_bte,
    input  wb_dat_sm, wb_ack
  );

  modport slave (
    input  wb_adr, wb_cyc, wb_stb, wb_we, wb_sel, wb_cti, wb_bte,
    output wb_dat_sm, wb_ack
  );

endinterface

// File: rtl/wshb_pixel_reader.sv
// Wishbone read initiator: streams the framebuffer in raster order as fixed-length incrementing
// bursts into the VGA pixel FIFO, releasing the bus for one cycle between bursts.
module wshb_pixel_reader
  import wshb_pkg::*;
#(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter int          BURST_LEN = 16,
  parameter logic [31:0] BASE_ADR  = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  wshb_pixel_reader_if.master        wb,
  output logic [15:0]                fifo_wdata,
  output logic                       fifo_write,
  input  logic                       fifo_afull,
  output logic                       frame_start,
  output rd_state_t                  dbg_state
);

  localparam int FRAME  = HDISP * VDISP;
  localparam int PIX_W  = $clog2(FRAME);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(FRAME - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [2:0]        CTI_FIRST = (BURST_LEN == 1) ? CTI_EOB : CTI_INCR;

  if ((HDISP * VDISP) % BURST_LEN != 0) begin : g_cfg_check
    $error("wshb_pixel_reader: HDISP*VDISP must be a multiple of BURST_LEN");
  end

  rd_state_t          state_q, state_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0]        adr_q, adr_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic [2:0]         cti_q, cti_d;
  logic               beat_ok;

  assign beat_ok = stb_q & wb.wb_ack & (state_q == RD_BURST);

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    beat_cnt_d = beat_cnt_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    cti_d      = cti_q;

    case (state_q)
      RD_IDLE: begin
        if (enable && !fifo_afull) begin
          state_d = RD_BURST;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cti_d   = CTI_FIRST;
        end
      end
      RD_BURST: begin
        // Without an ack every register holds, which covers any number of slave wait states.
        if (beat_ok) begin
          pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PIX_W'(1);
          if (beat_cnt_q == BEAT_LAST) begin
            state_d    = RD_GAP;
            beat_cnt_d = '0;
            cyc_d      = 1'b0;
            stb_d      = 1'b0;
            cti_d      = CTI_CLASSIC;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            cti_d      = (beat_cnt_q + BEAT_W'(1) == BEAT_LAST) ? CTI_EOB : CTI_INCR;
          end
        end
      end
      RD_GAP: begin
        // Dropping enable rewinds to pixel 0 so the next enable starts a fresh frame.
        if (!enable) begin
          state_d   = RD_IDLE;
          pix_cnt_d = '0;
        end else if (!fifo_afull) begin
          state_d = RD_BURST;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cti_d   = CTI_FIRST;
        end else begin
          state_d = RD_IDLE;
        end
      end
      default: begin
        state_d = RD_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        cti_d   = CTI_CLASSIC;
      end
    endcase

    adr_d = BASE_ADR + (32'(pix_cnt_d) << 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RD_IDLE;
      pix_cnt_q  <= '0;
      beat_cnt_q <= '0;
      adr_q      <= BASE_ADR;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      cti_q      <= CTI_CLASSIC;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      adr_q      <= adr_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      cti_q      <= cti_d;
    end
  end

  assign wb.wb_adr = adr_q;
  assign wb.wb_cyc = cyc_q;
  assign wb.wb_stb = stb_q;
  assign wb.wb_cti = cti_q;
  assign wb.wb_we  = 1'b0;
  assign wb.wb_sel = 2'b11;
  assign wb.wb_bte = BTE_LINEAR;

  assign fifo_wdata  = wb.wb_dat_sm;
  assign fifo_write  = beat_ok;
  assign frame_start = beat_ok & (pix_cnt_q == '0);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_wshb_pixel_reader.sv
// Bench for wshb_pixel_reader: a full-size instance (16-beat bursts) and a tiny-frame instance
// (8x4 frame, 8-beat bursts) each behind a Wishbone slave model returning adr[16:1].
module tb_wshb_pixel_reader;
  import wshb_pkg::*;

  localparam int BL_A    = 16;
  localparam int BL_B    = 8;
  localparam int FRAME_A = 800 * 480;
  localparam int FRAME_B = 8 * 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- stimulus knobs ----------------
  logic enable_a = 1'b0, afull_a = 1'b0, spur_a = 1'b0;
  logic enable_b = 1'b0, afull_b = 1'b0;
  int   waits_a = 0, waits_b = 0;
  int   wcnt_a, wcnt_b;

  wshb_pixel_reader_if if_a ();
  wshb_pixel_reader_if if_b ();

  logic [15:0] fifo_wdata_a, fifo_wdata_b;
  logic        fifo_write_a, fifo_write_b;
  logic        frame_start_a, frame_start_b;
  rd_state_t   dbg_a, dbg_b;

  wshb_pixel_reader #(.HDISP(800), .VDISP(480), .BURST_LEN(BL_A), .BASE_ADR(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .wb(if_a),
    .fifo_wdata(fifo_wdata_a), .fifo_write(fifo_write_a), .fifo_afull(afull_a),
    .frame_start(frame_start_a), .dbg_state(dbg_a)
  );

  wshb_pixel_reader #(.HDISP(8), .VDISP(4), .BURST_LEN(BL_B), .BASE_ADR(32'h0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .wb(if_b),
    .fifo_wdata(fifo_wdata_b), .fifo_write(fifo_write_b), .fifo_afull(afull_b),
    .frame_start(frame_start_b), .dbg_state(dbg_b)
  );

  // ---------------- slave models ----------------
  assign if_a.wb_ack    = (if_a.wb_stb && (wcnt_a >= waits_a)) || spur_a;
  assign if_a.wb_dat_sm = if_a.wb_adr[16:1];
  assign if_b.wb_ack    = if_b.wb_stb && (wcnt_b >= waits_b);
  assign if_b.wb_dat_sm = if_b.wb_adr[16:1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_a <= 0;
      wcnt_b <= 0;
    end else begin
      wcnt_a <= (if_a.wb_stb && !if_a.wb_ack) ? wcnt_a + 1 : 0;
      wcnt_b <= (if_b.wb_stb && !if_b.wb_ack) ? wcnt_b + 1 : 0;
    end
  end

  // ---------------- scoreboard ----------------
  // entry = {frame_start, cti[2:0], adr[31:0], data[15:0]}
  logic [51:0] exp_qa[$];
  logic [51:0] exp_qb[$];
  logic [51:0] e_a, e_b;
  int exp_pix_a = 0, exp_pix_b = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int qsize(input bit b);
    return b ? exp_qb.size() : exp_qa.size();
  endfunction

  task automatic push_burst(input bit b);
    int bl;
    bl = b ? BL_B : BL_A;
    for (int i = 0; i < bl; i++) begin
      int p;
      logic [51:0] v;
      p = b ? exp_pix_b : exp_pix_a;
      v = {(p == 0) ? 1'b1 : 1'b0, (i == bl - 1) ? 3'b111 : 3'b010, 32'(2 * p), 16'(p)};
      if (b) begin
        exp_qb.push_back(v);
        exp_pix_b = (p + 1) % FRAME_B;
      end else begin
        exp_qa.push_back(v);
        exp_pix_a = (p + 1) % FRAME_A;
      end
    end
  endtask

  // Monitor A: adr/cti must match the head entry on every strobe cycle (including waits);
  // the entry is consumed when the slave acks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_a.wb_stb) begin
        if (exp_qa.size() == 0) begin
          chk("a_unexpected_stb", 64'(if_a.wb_adr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e_a = exp_qa[0];
          chk("a_adr", 64'(if_a.wb_adr), 64'(e_a[47:16]));
          chk("a_cti", 64'(if_a.wb_cti), 64'(e_a[50:48]));
          chk("a_cyc", 64'(if_a.wb_cyc), 64'(1));
          chk("a_fifo_write", 64'(fifo_write_a), 64'(if_a.wb_ack));
          if (if_a.wb_ack) begin
            chk("a_wdata", 64'(fifo_wdata_a), 64'(e_a[15:0]));
            chk("a_frame_start", 64'(frame_start_a), 64'(e_a[51]));
            void'(exp_qa.pop_front());
          end
        end
      end else if (fifo_write_a || frame_start_a) begin
        chk("a_write_without_stb", 64'({fifo_write_a, frame_start_a}), 64'(0));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (if_b.wb_stb) begin
        if (exp_qb.size() == 0) begin
          chk("b_unexpected_stb", 64'(if_b.wb_adr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e_b = exp_qb[0];
          chk("b_adr", 64'(if_b.wb_adr), 64'(e_b[47:16]));
          chk("b_cti", 64'(if_b.wb_cti), 64'(e_b[50:48]));
          chk("b_fifo_write", 64'(fifo_write_b), 64'(if_b.wb_ack));
          if (if_b.wb_ack) begin
            chk("b_wdata", 64'(fifo_wdata_b), 64'(e_b[15:0]));
            chk("b_frame_start", 64'(frame_start_b), 64'(e_b[51]));
            void'(exp_qb.pop_front());
          end
        end
      end else if (fifo_write_b || frame_start_b) begin
        chk("b_write_without_stb", 64'({fifo_write_b, frame_start_b}), 64'(0));
      end
    end
  end

  // Gap monitor A: a cyc drop taken while enable=1 and afull=0 must last exactly one cycle.
  logic prev_cyc_a;
  bit   armed_a;
  int   lowcnt_a;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cyc_a = 1'b0;
      armed_a    = 1'b0;
      lowcnt_a   = 0;
    end else begin
      if (if_a.wb_cyc) begin
        if (!prev_cyc_a && armed_a) chk("a_gap_len", 64'(lowcnt_a), 64'(1));
        armed_a  = 1'b0;
        lowcnt_a = 0;
      end else begin
        if (prev_cyc_a) armed_a = enable_a && !afull_a;
        lowcnt_a++;
      end
      prev_cyc_a = if_a.wb_cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_below(input bit b, input int n, input int budget, input string name);
    int c;
    c = 0;
    while (qsize(b) >= n && c < budget) begin
      tick();
      c++;
    end
    chk(name, 64'(qsize(b) < n), 64'(1));
  endtask

  // Queue nbursts of expectations, let the DUT run, and stop it with afull during the last burst.
  task automatic run(input bit b, input int nbursts, input int waits);
    int bl, budget;
    bl     = b ? BL_B : BL_A;
    budget = nbursts * bl * (waits + 1) * 2 + 50;
    if (b) waits_b = waits; else waits_a = waits;
    repeat (nbursts) push_burst(b);
    if (b) begin afull_b = 1'b0; enable_b = 1'b1; end
    else   begin afull_a = 1'b0; enable_a = 1'b1; end
    wait_below(b, bl, budget, "run_last_burst_timeout");
    if (b) afull_b = 1'b1; else afull_a = 1'b1;
    wait_below(b, 1, budget, "run_drain_timeout");
    repeat (3) tick();
    if (b) chk("b_idle_cyc", 64'(if_b.wb_cyc), 64'(0));
    else   chk("a_idle_cyc", 64'(if_a.wb_cyc), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cyc", 64'(if_a.wb_cyc), 64'(0));
    chk("rst_stb", 64'(if_a.wb_stb), 64'(0));
    chk("rst_cti", 64'(if_a.wb_cti), 64'(3'b000));
    chk("rst_adr", 64'(if_a.wb_adr), 64'(0));
    chk("rst_fifo_write", 64'(fifo_write_a), 64'(0));
    chk("rst_frame_start", 64'(frame_start_a), 64'(0));
    chk("rst_state", 64'(dbg_a), 64'(3'b001));
    chk("rst_we", 64'(if_a.wb_we), 64'(0));
    chk("rst_sel", 64'(if_a.wb_sel), 64'(2'b11));
    chk("rst_bte", 64'(if_a.wb_bte), 64'(2'b00));
    chk("rst_b_cyc", 64'(if_b.wb_cyc), 64'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    // Ack with no strobe must not write the FIFO.
    spur_a = 1'b1;
    repeat (3) begin
      tick();
      chk("spur_fifo_write", 64'(fifo_write_a), 64'(0));
      chk("spur_frame_start", 64'(frame_start_a), 64'(0));
    end
    spur_a = 1'b0;

    // Zero-wait bursts, then afull holds the bus idle.
    run(1'b0, 3, 0);
    repeat (10) begin
      tick();
      chk("afull_hold_cyc", 64'(if_a.wb_cyc), 64'(0));
    end

    // Three wait states per beat; resumes at pixel 48.
    run(1'b0, 2, 3);

    // enable dropped after beat 5: burst finishes, then rewind to pixel 0.
    waits_a = 1;
    push_burst(1'b0);
    afull_a  = 1'b0;
    enable_a = 1'b1;
    wait_below(1'b0, 11, 200, "drop_timeout");
    enable_a = 1'b0;
    wait_below(1'b0, 1, 200, "drop_drain_timeout");
    repeat (4) tick();
    chk("drop_idle_cyc", 64'(if_a.wb_cyc), 64'(0));
    chk("drop_idle_state", 64'(dbg_a), 64'(3'b001));
    exp_pix_a = 0;
    run(1'b0, 1, 0);

    // Tiny frame: 4 bursts per frame, fifth burst wraps to pixel 0.
    run(1'b1, 5, 0);
    enable_b = 1'b0;

    // Reset during beat 7 of a burst.
    push_burst(1'b0);
    waits_a  = 3;
    afull_a  = 1'b0;
    enable_a = 1'b1;
    wait_below(1'b0, 10, 400, "rst_mid_timeout");
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", 64'(if_a.wb_cyc), 64'(0));
    chk("rst_mid_stb", 64'(if_a.wb_stb), 64'(0));
    chk("rst_mid_fifo_write", 64'(fifo_write_a), 64'(0));
    chk("rst_mid_state", 64'(dbg_a), 64'(3'b001));
    exp_qa.delete();
    exp_pix_a = 0;
    push_burst(1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_below(1'b0, BL_A, 400, "post_rst_timeout");
    afull_a = 1'b1;
    wait_below(1'b0, 1, 400, "post_rst_drain_timeout");
    repeat (3) tick();
    chk("post_rst_idle_cyc", 64'(if_a.wb_cyc), 64'(0));
    chk("final_queue_a", 64'(exp_qa.size()), 64'(0));
    chk("final_queue_b", 64'(exp_qb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t expected completion", $time);
    $fatal(1);
  end

endmodule
